// File: rtl/muldiv_if.sv
// Request/response channel between an issuing pipeline and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_value;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, funct3, rs1_val, rs2_val, rd, out_ready,
    input  in_ready, out_valid, out_value, out_rd
  );

  modport slave (
    input  in_valid, funct3, rs1_val, rs2_val, rd, out_ready,
    output in_ready, out_valid, out_value, out_rd
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: restoring divider and shift-add multiplier on
// operand magnitudes, with an optional single-cycle multiplier and early-out
// results for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  output logic     busy,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;    // sign of product / quotient
  logic              r_rneg;   // sign of remainder
  logic [XLEN-1:0]   r_hi;     // partial remainder / product high half
  logic [XLEN-1:0]   r_lo;     // quotient / multiplier bits shifting out
  logic [XLEN-1:0]   r_b;      // divisor / multiplicand magnitude
  logic [XLEN-1:0]   r_out_value;
  logic [4:0]        r_out_rd;

  // Apply the result sign and pick the part of the result the op returns.
  function automatic logic [XLEN-1:0] f_select(
    input logic [2:0]        op,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem,
    input logic              neg,
    input logic              rneg
  );
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    case (op)
      3'b000:                 f_select = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: f_select = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:         f_select = neg ? -quo : quo;
      default:                f_select = rneg ? -rem : rem;
    endcase
  endfunction

  // Request decode: operand signedness, magnitudes and early-out cases.
  logic              w_is_div, w_s1, w_s2, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_direct_val;
  logic              w_div0, w_ovf, w_direct, w_accept;
  logic [2*XLEN-1:0] w_fast_prod;

  assign w_is_div = bus.funct3[2];
  assign w_s1     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_s2     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign w_a_neg  = w_s1 && bus.rs1_val[XLEN-1];
  assign w_b_neg  = w_s2 && bus.rs2_val[XLEN-1];
  assign w_a_mag  = w_a_neg ? -bus.rs1_val : bus.rs1_val;
  assign w_b_mag  = w_b_neg ? -bus.rs2_val : bus.rs2_val;
  assign w_div0   = w_is_div && (bus.rs2_val == '0);
  assign w_ovf    = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                    (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
  assign w_direct = w_div0 || w_ovf || (FAST_MUL && !w_is_div);
  assign w_accept = bus.in_valid && (r_state == IDLE) && !flush;
  assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};

  // Early-out result chosen at the accepting edge.
  always_comb begin
    w_direct_val = '0;
    if (w_div0)
      w_direct_val = bus.funct3[1] ? bus.rs1_val : '1;
    else if (w_ovf)
      w_direct_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      w_direct_val = f_select(bus.funct3, w_fast_prod, '0, '0, w_a_neg ^ w_b_neg, 1'b0);
  end

  // One iteration step: restoring-divide bit or shift-add multiply bit.
  logic [XLEN:0]   w_rem_sh, w_sum;
  logic [XLEN+1:0] w_diff;
  logic            w_div_ok;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx;

  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_div_ok = !w_diff[XLEN+1];
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Select the divider or multiplier next-state for the working registers.
  always_comb begin
    w_hi_nx = w_sum[XLEN:1];
    w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      w_hi_nx = w_div_ok ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_div_ok};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = w_direct ? DONE : CALC;
      CALC: if (r_cnt == CW'(1)) w_state_next = DONE;
      DONE: if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_out_value <= '0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_op   <= bus.funct3;
      r_rd   <= bus.rd;
      r_neg  <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_cnt  <= w_direct ? '0 : CW'(XLEN);
      r_hi   <= '0;
      r_lo   <= w_is_div ? w_a_mag : w_b_mag;
      r_b    <= w_is_div ? w_b_mag : w_a_mag;
      if (w_direct) begin
        r_out_value <= w_direct_val;
        r_out_rd    <= bus.rd;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_out_value <= f_select(r_op, {w_hi_nx, w_lo_nx}, w_lo_nx, w_hi_nx, r_neg, r_rneg);
        r_out_rd    <= r_rd;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_value = r_out_value;
  assign bus.out_rd    = r_out_rd;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one fast-multiply and one iterative-multiply
// instance, driven by per-scenario tasks with hand-computed expectations.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy_f, busy_s;
  int checks = 0;
  int failures = 0;

  muldiv_if #(.XLEN(32)) bus_f();
  muldiv_if #(.XLEN(32)) bus_s();

  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy_f), .bus(bus_f.slave));
  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy_s), .bus(bus_s.slave));

  always #5 clk = ~clk;

  initial begin
    bus_f.in_valid = 0; bus_f.funct3 = 0; bus_f.rs1_val = 0; bus_f.rs2_val = 0;
    bus_f.rd = 0; bus_f.out_ready = 0;
    bus_s.in_valid = 0; bus_s.funct3 = 0; bus_s.rs1_val = 0; bus_s.rs2_val = 0;
    bus_s.rd = 0; bus_s.out_ready = 0;
  end

  // Issue one request to the chosen instance, wait (bounded) for the result,
  // report value/tag/latency, then complete the output handshake.
  task automatic run_op(input bit sel_s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rdi,
                        output logic [31:0] val, output logic [4:0] ord, output int lat);
    @(negedge clk);
    if (sel_s) begin
      bus_s.in_valid = 1; bus_s.funct3 = f; bus_s.rs1_val = a; bus_s.rs2_val = b; bus_s.rd = rdi;
    end else begin
      bus_f.in_valid = 1; bus_f.funct3 = f; bus_f.rs1_val = a; bus_f.rs2_val = b; bus_f.rd = rdi;
    end
    @(posedge clk); #1;
    bus_s.in_valid = 0; bus_f.in_valid = 0;
    lat = 1;
    while (!(sel_s ? bus_s.out_valid : bus_f.out_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    val = sel_s ? bus_s.out_value : bus_f.out_value;
    ord = sel_s ? bus_s.out_rd : bus_f.out_rd;
    $display("op sel_s=%0d f=%0d a=%h b=%h -> val=%h rd=%0d lat=%0d", sel_s, f, a, b, val, ord, lat);
    @(negedge clk);
    if (sel_s) bus_s.out_ready = 1; else bus_f.out_ready = 1;
    @(posedge clk); #1;
    bus_s.out_ready = 0; bus_f.out_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus_f.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus_f.out_valid); end
    checks++; if (bus_f.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus_f.in_ready); end
    checks++; if (busy_f !== 1'b0 || busy_s !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy_f, busy_s); end
    checks++; if (bus_f.out_value !== 32'h0 || bus_s.out_value !== 32'h0) begin failures++; $display("FAIL reset_out_value got=%h/%h exp=0", bus_f.out_value, bus_s.out_value); end
    checks++; if (bus_f.out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", bus_f.out_rd); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    $display("reset released");
  endtask

  task automatic test_div_special();
    logic [31:0] v; logic [4:0] r; int lat;
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd3, v, r, lat);
    checks++; if (v !== 32'h80000000) begin failures++; $display("FAIL div_ovf_val got=%h exp=80000000", v); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_ovf_lat got=%0d exp=1", lat); end
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd4, v, r, lat);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rem_ovf_val got=%h exp=0", v); end
    run_op(1, 3'b101, 32'h64, 32'h0, 5'd5, v, r, lat);
    checks++; if (v !== 32'hFFFFFFFF || lat !== 1) begin failures++; $display("FAIL divu_zero got=%h lat=%0d exp=ffffffff lat=1", v, lat); end
    run_op(1, 3'b111, 32'h64, 32'h0, 5'd6, v, r, lat);
    checks++; if (v !== 32'h64 || lat !== 1) begin failures++; $display("FAIL remu_zero got=%h lat=%0d exp=00000064 lat=1", v, lat); end
  endtask

  task automatic test_div_iter();
    logic [31:0] v; logic [4:0] r; int lat;
    run_op(0, 3'b100, 32'hFFFFFFF9, 32'h2, 5'd17, v, r, lat);
    checks++; if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_val got=%h exp=fffffffd", v); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_lat got=%0d exp=33", lat); end
    checks++; if (r !== 5'd17) begin failures++; $display("FAIL div_rd got=%0d exp=17", r); end
    run_op(1, 3'b110, 32'hFFFFFFF9, 32'h2, 5'd18, v, r, lat);
    checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg_val got=%h exp=ffffffff", v); end
    run_op(0, 3'b101, 32'd1000, 32'd7, 5'd19, v, r, lat);
    checks++; if (v !== 32'd142) begin failures++; $display("FAIL divu_val got=%0d exp=142", v); end
  endtask

  task automatic test_mul();
    logic [31:0] v; logic [4:0] r; int lat;
    run_op(0, 3'b001, 32'h80000000, 32'h80000000, 5'd7, v, r, lat);
    checks++; if (v !== 32'h40000000) begin failures++; $display("FAIL mulh_fast got=%h exp=40000000", v); end
    run_op(1, 3'b001, 32'h80000000, 32'h80000000, 5'd7, v, r, lat);
    checks++; if (v !== 32'h40000000) begin failures++; $display("FAIL mulh_slow got=%h exp=40000000", v); end
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, v, r, lat);
      checks++; if (v !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu s=%0d got=%h exp=fffffffe", s, v); end
      checks++; if (lat !== (s == 0 ? 1 : 33)) begin failures++; $display("FAIL mul_lat s=%0d got=%0d exp=%0d", s, lat, (s == 0 ? 1 : 33)); end
      run_op(s[0], 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, v, r, lat);
      checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu s=%0d got=%h exp=ffffffff", s, v); end
      run_op(s[0], 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, v, r, lat);
      checks++; if (v !== 32'h00000001) begin failures++; $display("FAIL mul s=%0d got=%h exp=00000001", s, v); end
      checks++; if (r !== 5'd10) begin failures++; $display("FAIL mul_rd s=%0d got=%0d exp=10", s, r); end
    end
  endtask

  task automatic test_stall();
    int lat;
    @(negedge clk);
    bus_f.in_valid = 1; bus_f.funct3 = 3'b000; bus_f.rs1_val = 32'd6; bus_f.rs2_val = 32'd7; bus_f.rd = 5'd21;
    @(posedge clk); #1;
    bus_f.funct3 = 3'b011; bus_f.rs1_val = 32'd2; bus_f.rs2_val = 32'd3; bus_f.rd = 5'd22;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus_f.out_valid !== 1'b1 || bus_f.out_value !== 32'd42 || bus_f.out_rd !== 5'd21 || bus_f.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall c=%0d got=v%b %h rd%0d rdy%b exp=v1 0000002a rd21 rdy0", c, bus_f.out_valid, bus_f.out_value, bus_f.out_rd, bus_f.in_ready);
      end
    end
    @(negedge clk); bus_f.out_ready = 1;
    @(posedge clk); #1;
    checks++; if (bus_f.in_ready !== 1'b1 || bus_f.out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=rdy%b v%b exp=rdy1 v0", bus_f.in_ready, bus_f.out_valid); end
    $display("stall released, in_ready=%b", bus_f.in_ready);
    bus_f.in_valid = 0; bus_f.out_ready = 0;
    lat = 0;
  endtask

  task automatic test_flush();
    logic [31:0] v; logic [4:0] r; int lat; int seen;
    @(negedge clk);
    bus_s.in_valid = 1; bus_s.funct3 = 3'b100; bus_s.rs1_val = 32'd100; bus_s.rs2_val = 32'd7; bus_s.rd = 5'd11;
    @(posedge clk); #1; bus_s.in_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1;
    @(posedge clk); #1; flush = 0;
    checks++; if (bus_s.in_ready !== 1'b1 || busy_s !== 1'b0) begin failures++; $display("FAIL flush_idle got=rdy%b busy%b exp=rdy1 busy0", bus_s.in_ready, busy_s); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (bus_s.out_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
    $display("flush done, out_valid cycles=%0d", seen);
    run_op(1, 3'b101, 32'd9, 32'd2, 5'd12, v, r, lat);
    checks++; if (v !== 32'd4) begin failures++; $display("FAIL post_flush_divu got=%0d exp=4", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v; logic [4:0] r; int lat;
    @(negedge clk);
    bus_f.in_valid = 1; bus_f.funct3 = 3'b100; bus_f.rs1_val = 32'd50; bus_f.rs2_val = 32'd3; bus_f.rd = 5'd13;
    @(posedge clk); #1; bus_f.in_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus_f.in_ready !== 1'b1 || busy_f !== 1'b0 || bus_f.out_valid !== 1'b0 || bus_f.out_value !== 32'h0 || bus_f.out_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid got=rdy%b busy%b v%b %h rd%0d exp=rdy1 busy0 v0 0 rd0", bus_f.in_ready, busy_f, bus_f.out_valid, bus_f.out_value, bus_f.out_rd);
    end
    $display("reset mid-CALC, busy=%b", busy_f);
    @(posedge clk); #2 rst_n = 1;
    run_op(0, 3'b101, 32'd9, 32'd2, 5'd14, v, r, lat);
    checks++; if (v !== 32'd4 || lat !== 33 || r !== 5'd14) begin failures++; $display("FAIL first_after_reset got=%0d lat=%0d rd%0d exp=4 lat=33 rd14", v, lat, r); end
  endtask

  initial begin
    test_reset();
    test_div_special();
    test_div_iter();
    test_mul();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter FAST_MUL, default 1: 1 gives a single-cycle multiply, 0 gives an iterative shift-add multiply.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 rs1_val  input  XLEN  first operand (dividend / multiplicand).
REQ-010 rs2_val  input  XLEN  second operand (divisor / multiplier).
REQ-011 rd  input  5  destination register tag.
REQ-012 flush  input  1  discard the in-flight operation.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_value  output  XLEN  result.
REQ-016 out_rd  output  5  destination tag of the result.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush; operands, funct3 and rd are captured at that edge.
REQ-020 On acceptance, the FSM SHALL go directly to DONE (latency 1, out_valid in the next cycle) for these cases:
- divide by zero;
- signed overflow;
- any multiply when FAST_MUL=1.
REQ-021 On acceptance, the FSM SHALL go to CALC otherwise, with the iteration counter loaded with XLEN.
REQ-022 In CALC, the unit SHALL perform one iteration per cycle: restoring divide (one quotient bit) or shift-add multiply (one multiplier bit).
REQ-023 After XLEN CALC cycles, the FSM SHALL enter DONE, so out_valid asserts exactly XLEN+1 cycles after the accepting edge.
REQ-024 Signed ops SHALL iterate on magnitudes, with signs fixed on the CALC-to-DONE transition:
- quotient negative iff operand signs differ;
- remainder takes the sign of the dividend;
- product negative iff the signs differ (MULHSU treats rs2 as unsigned).
REQ-025 The product SHALL be 2*XLEN bits; MUL returns bits [XLEN-1:0], and MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN].
REQ-026 For divisor = 0:
- DIV and DIVU SHALL return all ones;
- REM and REMU SHALL return rs1_val.
REQ-027 For DIV/REM with rs1 = most-negative and rs2 = all ones:
- DIV SHALL return most-negative;
- REM SHALL return 0.
REQ-028 In DONE, out_value and out_rd SHALL be held stable until out_valid && out_ready, then the FSM returns to IDLE on that edge.
REQ-029 No new request SHALL be accepted in the cycle of the output handshake.
REQ-030 flush=1 in any state SHALL force IDLE on the next edge, discard any result and suppress acceptance that cycle.
REQ-031 out_value and out_rd SHALL be registered; they are meaningful only when out_valid=1 and keep their last value otherwise.
REQ-032 funct3 SHALL select the op fully; there is no illegal encoding.

Reset
REQ-033 rst_n=0 SHALL immediately, independent of clk, force:
- state IDLE, so out_valid=0, busy=0 and in_ready=1;
- out_value=0 and out_rd=0;
- iteration counter=0.
REQ-034 Reset asserted mid-CALC or in DONE SHALL drop the operation with no result delivered.
REQ-035 The first acceptance after rst_n rises SHALL be possible on the first rising edge with rst_n=1.

Verification (XLEN=32)
REQ-036 Directed scenario: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, out_valid 1 cycle after accept; REM with the same operands -> 0x00000000.
REQ-037 Directed scenario: DIVU 0x64 / 0 -> 0xFFFFFFFF; REMU 0x64 / 0 -> 0x00000064; both at latency 1.
REQ-038 Directed scenario: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; out_valid exactly 33 cycles after accept, out_rd equals the captured rd.
REQ-039 Directed scenario: MULH 0x80000000 * 0x80000000 -> 0x40000000.
REQ-040 Directed scenario, operands 0xFFFFFFFF * 0xFFFFFFFF, run with FAST_MUL=1 and FAST_MUL=0 (latency 1 vs 33):
- MULHU -> 0xFFFFFFFE;
- MULHSU -> 0xFFFFFFFF;
- MUL -> 0x00000001.
REQ-041 Directed scenario: out_ready=0 for 5 cycles in DONE:
- out_valid, out_value and out_rd stay stable;
- in_ready stays 0 and in_valid is ignored;
- in_ready=1 in the cycle after the handshake.
REQ-042 Directed scenario: flush at cycle 10 of a DIV CALC:
- out_valid never asserts and in_ready=1 on the next cycle;
- the next DIVU 9/2 returns 4.
- Separately, rst_n pulsed low mid-CALC gives IDLE immediately and all outputs at reset values.
